weight_window_addr_gen: RTL and testbench



---
 rtl/weight_window_addr_gen_pkg.sv | 22 ++
 rtl/weight_window_addr_gen_if.sv | 31 +++
 rtl/weight_window_addr_gen_win_counter.sv | 38 +++
 rtl/weight_window_addr_gen.sv | 107 ++++++++++
 tb/tb_weight_window_addr_gen.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/weight_window_addr_gen_pkg.sv
// Shared definitions for the weight / input / output address generators.
//   state_t        : window FSM state (IDLE, RUN, DONE)
//   DEF_*_STRIDE   : default address strides of the weight layout
//   cnt_w()        : counter width for a modulus, never below one bit
package weight_window_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ROW_STRIDE   = 16;
  localparam int DEF_COL_STRIDE_J = 4;
  localparam int DEF_CH_STRIDE    = 64;

  // A modulus of 1 still needs a one-bit counter that stays at zero.
  function automatic int cnt_w(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/weight_window_addr_gen_if.sv
// Request/address bus of the weight window address generator.
//   start, col_major, i, j, k : window request from the layer controller
//   ready                     : weight SRAM read port accepts addr
//   addr, addr_valid, last    : address beat towards the SRAM
//   busy, done                : status back to the controller
// master: controller/consumer side; slave: the generator.
interface weight_window_addr_gen_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              col_major;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        k;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    output start, col_major, i, j, k, ready,
    input  addr, addr_valid, last, busy, done
  );

  modport slave (
    input  start, col_major, i, j, k, ready,
    output addr, addr_valid, last, busy, done
  );
endinterface

// File: rtl/weight_window_addr_gen_win_counter.sv
// Modulus counter used for the window row and column indices.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : advance by one (wraps MOD-1 -> 0)
//   clear     : synchronous return to zero, wins over en
//   count     : registered count
//   count_nxt : value count takes at the next edge
//   wrap      : count sits at MOD-1, so the next advance wraps; it does not
//               depend on en, which lets the caller chain inner -> outer
//               enables without a combinational loop
module win_counter
  import weight_window_addr_gen_pkg::*;
#(
  parameter  int MOD = 2,
  localparam int CW  = cnt_w(MOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          wrap
);
  localparam logic [CW-1:0] TOP = CW'(MOD - 1);

  assign wrap = (count == TOP);

  always_comb begin
    count_nxt = count;
    if (clear)   count_nxt = '0;
    else if (en) count_nxt = wrap ? '0 : count + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end
endmodule

// File: rtl/weight_window_addr_gen.sv
// Weight-memory address generator for one KH x KW convolution window.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of weight_window_addr_gen_if
//              start/col_major/i/j/k latched in IDLE; ready is backpressure;
//              addr/addr_valid/last/busy/done are all flop outputs.
// addr = (base + ROW_STRIDE*r + c) mod HEIGHT, base = CH_STRIDE*k +
// COL_STRIDE_J*j + I_STRIDE*i. col_major=0 runs r fastest, 1 runs c fastest.
module weight_window_addr_gen
  import weight_window_addr_gen_pkg::*;
#(
  parameter  int KH           = 2,
  parameter  int KW           = 2,
  parameter  int ROW_STRIDE   = DEF_ROW_STRIDE,
  parameter  int COL_STRIDE_J = DEF_COL_STRIDE_J,
  parameter  int CH_STRIDE    = DEF_CH_STRIDE,
  parameter  int I_STRIDE     = 0,
  parameter  int HEIGHT       = 256,
  localparam int ADDR_W       = $clog2(HEIGHT)
) (
  input logic                    clk,
  input logic                    rst,
  weight_window_addr_gen_if.slave bus
);
  localparam int RW = cnt_w(KH);
  localparam int CW = cnt_w(KW);
  localparam logic [RW-1:0] R_TOP = RW'(KH - 1);
  localparam logic [CW-1:0] C_TOP = CW'(KW - 1);

  state_t            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic              cm_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, last_q, busy_q, done_q;
  logic              last_d;

  logic          hs, go;
  logic          r_en, c_en, r_wrap, c_wrap;
  logic [RW-1:0] r_cnt, r_nxt;
  logic [CW-1:0] c_cnt, c_nxt;

  assign hs = valid_q & bus.ready;
  assign go = (state_q == IDLE) & bus.start;

  // Inner index steps on every handshake; outer steps when inner wraps.
  assign r_en = hs & (cm_q ? c_wrap : 1'b1);
  assign c_en = hs & (cm_q ? 1'b1 : r_wrap);

  win_counter #(.MOD(KH)) u_row (
    .clk(clk), .rst(rst), .en(r_en), .clear(go),
    .count(r_cnt), .count_nxt(r_nxt), .wrap(r_wrap)
  );

  win_counter #(.MOD(KW)) u_col (
    .clk(clk), .rst(rst), .en(c_en), .clear(go),
    .count(c_cnt), .count_nxt(c_nxt), .wrap(c_wrap)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    if (go)
      base_d = 32'(CH_STRIDE) * 32'(bus.k) + 32'(COL_STRIDE_J) * 32'(bus.j)
             + 32'(I_STRIDE) * 32'(bus.i);
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (hs && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from next-state values so they can be flops.
    addr_d = addr_q;
    last_d = 1'b0;
    if (state_d == RUN) begin
      addr_d = ADDR_W'(base_d + 32'(ROW_STRIDE) * 32'(r_nxt) + 32'(c_nxt));
      last_d = (r_nxt == R_TOP) && (c_nxt == C_TOP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cm_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      if (go) cm_q <= bus.col_major;
      addr_q  <= addr_d;
      valid_q <= (state_d == RUN);
      last_q  <= last_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_weight_window_addr_gen.sv
// Self-checking bench for weight_window_addr_gen at default parameters
// (2x2 window, strides 16/4/64/0, HEIGHT 256).
module tb_weight_window_addr_gen;
  localparam int HEIGHT = 256;
  localparam int AW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_window_addr_gen_if #(.ADDR_W(AW)) bus();

  weight_window_addr_gen dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  typedef struct {
    int             k;
    int             j;
    bit             cm;
    logic [3:0][7:0] e;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int k, int j, bit cm, int a0, int a1, int a2, int a3);
    vec_t v;
    v.k = k; v.j = j; v.cm = cm;
    v.e[0] = 8'(a0); v.e[1] = 8'(a1); v.e[2] = 8'(a2); v.e[3] = 8'(a3);
    return v;
  endfunction

  // Reference: walk the window in nested loops, inner index fastest.
  function automatic void build_exp(int kk, int jj, int ii, bit cm);
    int base;
    base = 64 * kk + 4 * jj + 0 * ii;
    exp_q.delete();
    for (int o = 0; o < 2; o++)
      for (int n = 0; n < 2; n++) begin
        if (!cm) exp_q.push_back((base + 16 * n + o) % HEIGHT);
        else     exp_q.push_back((base + 16 * o + n) % HEIGHT);
      end
  endfunction

  // mode 0: ready high; 1: random ready and start noise;
  // 2: ready low 3 cycles on beat stall_beat; 3: start held high throughout
  task automatic run_win(input int kk, input int jj, input int ii, input bit cm,
                         input int mode, input int stall_beat);
    int idx, cyc, stall;
    bit rdy;
    @(negedge clk);
    bus.start = 1'b1; bus.k = 8'(kk); bus.j = 8'(jj); bus.i = 8'(ii);
    bus.col_major = cm; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = (mode == 3);
    bus.k = 8'($urandom); bus.j = 8'($urandom); bus.i = 8'($urandom);
    bus.col_major = 1'($urandom);
    chk("first_valid", bus.addr_valid, 1);
    idx = 0; cyc = 0; stall = 0;
    while (idx < exp_q.size() && cyc < 300) begin
      rdy = 1'b1;
      if (mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
        bus.start = 1'($urandom_range(0, 1));
      end
      if (mode == 2 && idx == stall_beat && stall < 3) begin
        rdy = 1'b0;
        stall++;
        chk("hold_valid", bus.addr_valid, 1);
        chk("hold_addr", bus.addr, exp_q[idx]);
      end
      bus.ready = rdy;
      if (!bus.addr_valid) begin
        chk("valid_in_run", bus.addr_valid, 1);
      end else if (rdy) begin
        chk($sformatf("addr[%0d]", idx), bus.addr, exp_q[idx]);
        chk($sformatf("last[%0d]", idx), bus.last, (idx == exp_q.size() - 1));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < exp_q.size()) chk("window_timeout", idx, exp_q.size());
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_valid", bus.addr_valid, 0);
    if (mode == 1) bus.start = 1'($urandom_range(0, 1));
    bus.ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    if (mode == 3) begin
      @(negedge clk);
      chk("no_restart_busy", bus.busy, 0);
      chk("no_restart_valid", bus.addr_valid, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.col_major = 1'b0; bus.ready = 1'b0;
    bus.i = '0; bus.j = '0; bus.k = '0;

    vt[0] = mk(1, 2, 1'b0, 72, 88, 73, 89);
    vt[1] = mk(1, 2, 1'b1, 72, 73, 88, 89);
    vt[2] = mk(3, 63, 1'b0, 188, 204, 189, 205);
    vt[3] = mk(3, 63, 1'b1, 188, 189, 204, 205);
    vt[4] = mk(0, 0, 1'b0, 0, 16, 1, 17);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_addr", bus.addr, 0);
    chk("rst_valid", bus.addr_valid, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;

    // Directed table
    for (int t = 0; t < 5; t++) begin
      exp_q.delete();
      for (int b = 0; b < 4; b++) exp_q.push_back(int'(vt[t].e[b]));
      run_win(vt[t].k, vt[t].j, 0, vt[t].cm, 0, 0);
    end

    // Backpressure on the second beat
    build_exp(1, 2, 0, 1'b0);
    run_win(1, 2, 0, 1'b0, 2, 1);

    // start held high during RUN and DONE
    build_exp(1, 2, 0, 1'b1);
    run_win(1, 2, 0, 1'b1, 3, 0);

    // Reset after the second beat
    build_exp(1, 2, 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.k = 8'd1; bus.j = 8'd2; bus.i = 8'd0;
    bus.col_major = 1'b0; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mid_beat0", bus.addr, 72);
    @(negedge clk);
    chk("mid_beat1", bus.addr, 88);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", bus.addr, 0);
    chk("mid_rst_valid", bus.addr_valid, 0);
    chk("mid_rst_last", bus.last, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_busy", bus.busy, 0);
    build_exp(0, 0, 0, 1'b0);
    run_win(0, 0, 0, 1'b0, 0, 0);

    // Randomized windows with random backpressure
    for (int n = 0; n < 25; n++) begin
      int rk, rj, ri;
      bit rc;
      rk = $urandom_range(0, 255);
      rj = $urandom_range(0, 255);
      ri = $urandom_range(0, 255);
      rc = 1'($urandom_range(0, 1));
      build_exp(rk, rj, ri, rc);
      run_win(rk, rj, ri, rc, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
